// File: rtl/pipeline_debug_ctrl.sv
// Debug pipeline sequencer: free-run or single-step execution, stop on HALT,
// then stream the whole register bank out byte by byte (LSB byte first).
// Register-bank read port A belongs to the dump engine only while frozen.
module pipeline_debug_ctrl #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int N_REGS  = 32,
   parameter int NB_BYTE = 8,
   parameter int NB_CNT  = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start_cont,
   input  logic               i_step,
   input  logic               i_halt,
   output logic               o_pipe_enable,
   output logic               o_dbg_grant,
   output logic [NB_REG-1:0]  o_dbg_reg_sel,
   input  logic [NB_DATA-1:0] i_dbg_reg_data,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_done,
   output logic [NB_CNT-1:0]  o_cycle_count
);

   localparam int N_BYTES = NB_DATA / NB_BYTE;
   localparam int NB_BIDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(N_BYTES - 1);
   localparam logic [NB_REG-1:0]  LAST_REG  = NB_REG'(N_REGS - 1);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      STEP,
      DUMP_ADDR,
      DUMP_LATCH,
      DUMP_SEND,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic                halted_q, halted_d;
   logic [NB_REG-1:0]   reg_idx_q, reg_idx_d;
   logic [NB_BIDX-1:0]  byte_idx_q, byte_idx_d;
   logic [NB_DATA-1:0]  shift_q, shift_d;

   logic                pipe_enable_q, pipe_enable_d;
   logic                grant_q, grant_d;
   logic [NB_REG-1:0]   reg_sel_q, reg_sel_d;
   logic [NB_BYTE-1:0]  tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [NB_CNT-1:0]   cycle_count_q, cycle_count_d;

   // Next-state logic; every output is decoded from the next state so that it is a flop.
   always_comb begin
      state_d    = state_q;
      halted_d   = halted_q;
      reg_idx_d  = reg_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      tx_data_d  = tx_data_q;

      case (state_q)
         IDLE: begin
            if (i_start_cont) begin
               state_d  = RUN;
               halted_d = 1'b0;
            end else if (i_step) begin
               state_d  = STEP;
               halted_d = 1'b0;
            end
         end
         RUN: begin
            if (i_halt) begin
               state_d  = DUMP_ADDR;
               halted_d = 1'b1;
            end
         end
         STEP: begin
            state_d  = DUMP_ADDR;
            halted_d = i_halt;
         end
         DUMP_ADDR: begin
            state_d = DUMP_LATCH;
         end
         DUMP_LATCH: begin
            shift_d    = i_dbg_reg_data;
            byte_idx_d = '0;
            tx_data_d  = i_dbg_reg_data[NB_BYTE-1:0];
            state_d    = DUMP_SEND;
         end
         DUMP_SEND: begin
            if (i_tx_ready) begin
               if (byte_idx_q == LAST_BYTE) begin
                  byte_idx_d = '0;
                  if (reg_idx_q == LAST_REG) begin
                     reg_idx_d = '0;
                     state_d   = halted_q ? DONE : IDLE;
                  end else begin
                     reg_idx_d = reg_idx_q + 1'b1;
                     state_d   = DUMP_ADDR;
                  end
               end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
                  shift_d    = shift_q >> NB_BYTE;
                  tx_data_d  = shift_d[NB_BYTE-1:0];
               end
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      pipe_enable_d = (state_d == RUN) || (state_d == STEP);
      grant_d       = (state_d == DUMP_ADDR) || (state_d == DUMP_LATCH) || (state_d == DUMP_SEND);
      reg_sel_d     = grant_d ? reg_idx_d : '0;
      tx_valid_d    = (state_d == DUMP_SEND);
      busy_d        = !((state_d == IDLE) || (state_d == DONE));
      done_d        = (state_d == DONE);
      cycle_count_d = cycle_count_q + NB_CNT'(pipe_enable_q);
   end

   // State and output registers with synchronous reset taking priority everywhere.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q       <= IDLE;
         halted_q      <= 1'b0;
         reg_idx_q     <= '0;
         byte_idx_q    <= '0;
         shift_q       <= '0;
         pipe_enable_q <= 1'b0;
         grant_q       <= 1'b0;
         reg_sel_q     <= '0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         halted_q      <= halted_d;
         reg_idx_q     <= reg_idx_d;
         byte_idx_q    <= byte_idx_d;
         shift_q       <= shift_d;
         pipe_enable_q <= pipe_enable_d;
         grant_q       <= grant_d;
         reg_sel_q     <= reg_sel_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign o_pipe_enable = pipe_enable_q;
   assign o_dbg_grant   = grant_q;
   assign o_dbg_reg_sel = reg_sel_q;
   assign o_tx_data     = tx_data_q;
   assign o_tx_valid    = tx_valid_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Testbench for pipeline_debug_ctrl: single step, run to halt with
// backpressure, command collisions and reset in the middle of a dump.
module tb_pipeline_debug_ctrl;

   logic        i_clock;
   logic        i_reset;
   logic        i_start_cont;
   logic        i_step;
   logic        i_halt;
   logic        o_pipe_enable;
   logic        o_dbg_grant;
   logic [4:0]  o_dbg_reg_sel;
   logic [31:0] i_dbg_reg_data;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_cycle_count;

   logic [31:0] bank [32];
   logic [7:0]  rxq [$];
   logic [7:0]  expq [$];
   logic [4:0]  selq [$];

   int checks = 0;
   int errors = 0;

   logic       prev_grant = 1'b0;
   logic [4:0] prev_sel = '0;
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = '0;
   logic       expect_drop = 1'b0;
   int         xfers = 0;

   pipeline_debug_ctrl dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_start_cont   (i_start_cont),
      .i_step         (i_step),
      .i_halt         (i_halt),
      .o_pipe_enable  (o_pipe_enable),
      .o_dbg_grant    (o_dbg_grant),
      .o_dbg_reg_sel  (o_dbg_reg_sel),
      .i_dbg_reg_data (i_dbg_reg_data),
      .o_tx_data      (o_tx_data),
      .o_tx_valid     (o_tx_valid),
      .i_tx_ready     (i_tx_ready),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_cycle_count  (o_cycle_count)
   );

   // Register bank model with a combinational read on port A.
   assign i_dbg_reg_data = bank[o_dbg_reg_sel];

   // Free-running clock, 10 time units per period.
   initial begin
      i_clock = 1'b0;
      forever #5 i_clock = ~i_clock;
   end

   // Watchdog so a stuck design can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, and reports tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive all inputs for the next edge, then move to just after that edge.
   task automatic applyStimulus(input logic start, input logic step, input logic halt,
                                input logic rst, input logic ready);
      i_start_cont = start;
      i_step       = step;
      i_halt       = halt;
      i_reset      = rst;
      i_tx_ready   = ready;
      @(posedge i_clock);
      #2;
   endtask

   // Expected dump: every register in address order, least significant byte first.
   task automatic buildFrame();
      expq.delete();
      for (int k = 0; k < 32; k++)
         for (int b = 0; b < 4; b++)
            expq.push_back(bank[k][8*b +: 8]);
   endtask

   // Compare the captured stream and the read-address sequence against the model.
   task automatic checkFrame(input string tag);
      checkOutput({tag, "_len"}, rxq.size(), expq.size());
      for (int i = 0; i < rxq.size() && i < expq.size(); i++)
         checkOutput($sformatf("%s_byte%0d", tag, i), rxq[i], expq[i]);
      checkOutput({tag, "_sel_len"}, selq.size(), 32);
      for (int i = 0; i < selq.size() && i < 32; i++)
         checkOutput($sformatf("%s_sel%0d", tag, i), selq[i], i);
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int n = 0;
      while (o_busy && n < budget) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         n++;
      end
      checkOutput({tag, "_finish"}, o_busy, 0);
   endtask

   // Per-cycle monitor on the falling edge: exclusivity, stream capture, hold and bubbles.
   always @(negedge i_clock) begin
      checkOutput("arb_exclusive", o_pipe_enable & o_dbg_grant, 0);
      if (i_reset) begin
         xfers       = 0;
         expect_drop = 1'b0;
         prev_hold   = 1'b0;
      end else begin
         if (expect_drop) begin
            checkOutput("bubble_after_reg", o_tx_valid, 0);
            expect_drop = 1'b0;
         end
         if (prev_hold) begin
            checkOutput("hold_valid", o_tx_valid, 1);
            checkOutput("hold_data", o_tx_data, prev_data);
         end
         if (o_tx_valid && i_tx_ready) begin
            rxq.push_back(o_tx_data);
            xfers++;
            if (xfers == 4) begin
               expect_drop = 1'b1;
               xfers       = 0;
            end
         end
         prev_hold = o_tx_valid && !i_tx_ready;
         prev_data = o_tx_data;
         if (o_dbg_grant && (!prev_grant || o_dbg_reg_sel != prev_sel))
            selq.push_back(o_dbg_reg_sel);
      end
      prev_grant = o_dbg_grant;
      prev_sel   = o_dbg_reg_sel;
   end

   // Directed sequence of scenarios.
   initial begin
      int n;
      i_reset      = 1'b1;
      i_start_cont = 1'b0;
      i_step       = 1'b0;
      i_halt       = 1'b0;
      i_tx_ready   = 1'b0;
      for (int k = 0; k < 32; k++) bank[k] = 32'h0;

      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("rst_enable", o_pipe_enable, 0);
      checkOutput("rst_grant", o_dbg_grant, 0);
      checkOutput("rst_sel", o_dbg_reg_sel, 0);
      checkOutput("rst_valid", o_tx_valid, 0);
      checkOutput("rst_data", o_tx_data, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_done", o_done, 0);
      checkOutput("rst_count", o_cycle_count, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("idle_enable", o_pipe_enable, 0);

      $display("[TB] single step");
      for (int k = 0; k < 32; k++) bank[k] = k * 32'h01010101;
      buildFrame();
      rxq.delete();
      selq.delete();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("step_enable_on", o_pipe_enable, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("step_enable_off", o_pipe_enable, 0);
      checkOutput("step_grant", o_dbg_grant, 1);
      waitIdle("step_dump", 2000);
      checkFrame("step");
      if (rxq.size() >= 8) begin
         checkOutput("step_r0", {rxq[3], rxq[2], rxq[1], rxq[0]}, 32'h00000000);
         checkOutput("step_r1", {rxq[7], rxq[6], rxq[5], rxq[4]}, 32'h01010101);
      end
      checkOutput("step_done", o_done, 0);
      checkOutput("step_count", o_cycle_count, 1);
      checkOutput("step_grant_idle", o_dbg_grant, 0);

      $display("[TB] run to halt with collision and backpressure");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("run_pre_count", o_cycle_count, 0);
      for (int k = 0; k < 32; k++) bank[k] = $urandom();
      bank[5] = 32'hDEADBEEF;
      buildFrame();
      rxq.delete();
      selq.delete();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("collision_enable_c1", o_pipe_enable, 1);
      for (int c = 2; c <= 25; c++) begin
         applyStimulus(1'b0, (c == 10) || (c == 17), 1'b0, 1'b0, 1'b1);
         checkOutput($sformatf("run_enable_c%0d", c), o_pipe_enable, 1);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("halt_enable_drop", o_pipe_enable, 0);
      checkOutput("halt_grant", o_dbg_grant, 1);
      checkOutput("halt_count", o_cycle_count, 25);
      n = 0;
      while (o_busy && n < 20000) begin
         applyStimulus(1'b0, (n % 11) == 3, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         n++;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("run_dump_finish", o_busy, 0);
      checkFrame("run");
      if (rxq.size() >= 24)
         checkOutput("run_r5", {rxq[23], rxq[22], rxq[21], rxq[20]}, 32'hDEADBEEF);
      checkOutput("run_done", o_done, 1);
      checkOutput("run_count", o_cycle_count, 25);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("done_enable", o_pipe_enable, 0);
         checkOutput("done_sticky", o_done, 1);
      end
      checkOutput("done_count", o_cycle_count, 25);

      $display("[TB] reset during dump");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rxq.delete();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (9) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("mid_halt_count", o_cycle_count, 10);
      n = 0;
      while (rxq.size() < 37 && n < 2000) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         n++;
      end
      checkOutput("mid_bytes_sent", rxq.size(), 37);
      checkOutput("mid_byte37_valid", o_tx_valid, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("mid_rst_enable", o_pipe_enable, 0);
      checkOutput("mid_rst_grant", o_dbg_grant, 0);
      checkOutput("mid_rst_sel", o_dbg_reg_sel, 0);
      checkOutput("mid_rst_valid", o_tx_valid, 0);
      checkOutput("mid_rst_data", o_tx_data, 0);
      checkOutput("mid_rst_busy", o_busy, 0);
      checkOutput("mid_rst_done", o_done, 0);
      checkOutput("mid_rst_count", o_cycle_count, 0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("post_rst_idle_enable", o_pipe_enable, 0);
      checkOutput("post_rst_idle_busy", o_busy, 0);
      checkOutput("post_rst_idle_valid", o_tx_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
